// File: rtl/bitty_fetch_unit_if.sv
// Memory read port and core instruction/run/done handshake of the bitty fetch unit.
interface bitty_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic [15:0]       instruction;
    logic              run;
    logic              done;

    // Fetch unit side: issues reads and instructions.
    modport master (
        output mem_rd_en, mem_addr, instruction, run,
        input  mem_data, done
    );

    // Memory/core side: returns read data and completion.
    modport slave (
        input  mem_rd_en, mem_addr, instruction, run,
        output mem_data, done
    );
endinterface

// File: rtl/bitty_fetch_unit.sv
// Instruction sequencer for the bitty core: fetch at pc, issue with a run pulse,
// wait for done, advance pc. Stops on HALT_INSTR or on a done timeout.
module bitty_fetch_unit #(
    parameter int          ADDR_W     = 8,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF,
    parameter int          TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    bitty_fetch_unit_if.master bus,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_MEM_WAIT, S_ISSUE, S_EXEC, S_HALT, S_ERROR
    } state_t;

    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Error is taken on the EXEC edge where the counter would step onto TIMEOUT-1,
    // so timeout_err rises exactly TIMEOUT cycles after run rises.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 2);

    state_t            state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              rd_en_q;
    logic              run_q;
    logic [15:0]       instr_q;

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = pc;
    assign bus.instruction = instr_q;
    assign bus.run         = run_q;

    // Sequencer FSM; every output is a register updated with the transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr_count <= '0;
            tmo_cnt     <= '0;
            instr_q     <= '0;
            rd_en_q     <= 1'b0;
            run_q       <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            run_q   <= 1'b0;
            case (state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        pc          <= start_addr;
                        instr_count <= '0;
                        halted      <= 1'b0;
                        timeout_err <= 1'b0;
                        rd_en_q     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    instr_q <= bus.mem_data;
                    if (bus.mem_data == HALT_INSTR) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_HALT;
                    end else begin
                        run_q <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    // done wins over a timeout on the same edge
                    if (bus.done) begin
                        pc <= pc + 1'b1;
                        if (instr_count != 16'hFFFF)
                            instr_count <= instr_count + 16'd1;
                        rd_en_q <= 1'b1;
                        state   <= S_FETCH;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt     <= tmo_cnt + 1'b1;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Self-checking bench: memory and core models, program-level reference model.
module tb_bitty_fetch_unit;
    localparam int          TIMEOUT = 64;
    localparam logic [15:0] HALT    = 16'hFFFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] pc;
    logic [15:0] instr_count;
    logic       busy, halted, timeout_err;

    bitty_fetch_unit_if #(.ADDR_W(8)) bus ();

    bitty_fetch_unit #(.ADDR_W(8), .HALT_INSTR(HALT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .bus(bus),
        .pc(pc), .instr_count(instr_count), .busy(busy), .halted(halted),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Synchronous-read instruction memory, one-cycle latency.
    logic [15:0] mem [256];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_data <= mem[bus.mem_addr];

    // Core model: done is sampled by the DUT L+2 edges after run rises,
    // L taken per run from core_lat_q. spur_en adds done pulses outside EXEC.
    int          core_lat_q[$];
    logic [15:0] run_log[$];
    bit          spur_en = 0;
    int          cd = 0;
    int          cur;
    bit          spur_d = 0;
    always @(posedge clk) begin
        bus.done <= 1'b0;
        if (bus.run) begin
            run_log.push_back(bus.instruction);
            cur = (core_lat_q.size() > 0) ? core_lat_q.pop_front() : TIMEOUT + 4;
            if (cur == 0) bus.done <= 1'b1;
            else cd = cur;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) bus.done <= 1'b1;
        end
        if (spur_en && (!busy || bus.mem_rd_en || spur_d)) bus.done <= 1'b1;
        spur_d = bus.mem_rd_en;
    end

    int lat_q[$];

    // Runs one program from sa and checks it against the reference model.
    task automatic run_prog(input logic [7:0] sa);
        logic [15:0] exp_instr[$];
        int          gaps[$];
        int          run_cyc[$];
        logic [7:0]  a = sa;
        int          exp_t = 0, exp_cnt = 0, li = 0, lat;
        bit          ex_halt = 0, ex_tmo = 0;
        int          cyc, nrd = 0, first_rd = -1, tmo_cyc = -1, base;

        // Reference: walk the program word by word.
        for (int g = 0; g < 300; g++) begin
            if (mem[a] == HALT) begin ex_halt = 1; exp_t += 2; break; end
            exp_instr.push_back(mem[a]);
            lat = (li < lat_q.size()) ? lat_q[li] : TIMEOUT + 4;
            li++;
            if (lat + 2 > TIMEOUT) begin ex_tmo = 1; exp_t += 2 + TIMEOUT; break; end
            exp_t += lat + 4;
            gaps.push_back(lat + 4);
            exp_cnt++;
            a = a + 8'd1;
        end

        core_lat_q = lat_q;
        base = run_log.size();
        @(negedge clk);
        start_addr = sa;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk("flags_clr", {30'd0, halted, timeout_err}, 32'd0);
        forever begin
            if (bus.mem_rd_en) begin nrd++; if (first_rd < 0) first_rd = cyc; end
            if (bus.run) run_cyc.push_back(cyc);
            if (timeout_err && tmo_cyc < 0) tmo_cyc = cyc;
            if (!busy || cyc >= 3000) break;
            if (spur_en && $urandom_range(0, 3) == 0) begin
                start_addr = 8'($urandom);
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk("bound", {31'd0, busy}, 32'd0);
        chk("cycles", cyc, exp_t + 1);
        chk("rd_lat", first_rd, 1);
        chk("n_fetch", nrd, exp_instr.size() + (ex_halt ? 1 : 0));
        chk("n_run", run_cyc.size(), exp_instr.size());
        chk("n_log", run_log.size() - base, exp_instr.size());
        if (run_cyc.size() > 0 && run_cyc.size() == exp_instr.size()) begin
            chk("run_lat", run_cyc[0], 3);
            for (int i = 0; i < exp_instr.size() && base + i < run_log.size(); i++)
                chk("instr", run_log[base + i], exp_instr[i]);
            for (int i = 0; i + 1 < run_cyc.size() && i < gaps.size(); i++)
                chk("run_gap", run_cyc[i + 1] - run_cyc[i], gaps[i]);
            if (ex_tmo) chk("tmo_lat", tmo_cyc - run_cyc[run_cyc.size() - 1], TIMEOUT);
        end
        chk("pc", pc, a);
        chk("count", instr_count, exp_cnt);
        chk("halted", halted, ex_halt);
        chk("tmo_err", timeout_err, ex_tmo);
        repeat (20) @(posedge clk);
    endtask

    initial begin
        int sa, n, to;
        for (int i = 0; i < 256; i++) mem[i] = HALT;
        bus.done = 1'b0;
        bus.mem_data = 16'h0;
        reset = 1'b0;
        start = 1'b0;
        start_addr = 8'h0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_run", bus.run, 0);
        chk("rst_rd", bus.mem_rd_en, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_flags", {halted, timeout_err}, 0);
        chk("rst_instr", bus.instruction, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Basic program
        mem[8'h10] = 16'h1234; mem[8'h11] = 16'h5678; mem[8'h12] = HALT;
        lat_q = '{3, 3};
        run_prog(8'h10);
        chk("hold_instr", bus.instruction, HALT);

        // Address wrap
        mem[8'hFF] = 16'h0001; mem[8'h00] = HALT;
        lat_q = '{2};
        run_prog(8'hFF);

        // Timeout, then the next start clears it
        mem[8'h20] = 16'hABCD;
        lat_q = '{TIMEOUT + 4};
        run_prog(8'h20);
        mem[8'h21] = HALT;
        lat_q = '{};
        run_prog(8'h21);

        // done on the last allowed edge wins; one later times out
        mem[8'h30] = 16'h0030; mem[8'h31] = 16'h0031; mem[8'h32] = HALT;
        lat_q = '{TIMEOUT - 2, TIMEOUT - 1};
        run_prog(8'h30);

        // Spurious done and start while busy
        spur_en = 1;
        lat_q = '{0, 5};
        run_prog(8'h30);
        spur_en = 0;

        // Randomized programs
        for (int p = 0; p < 10; p++) begin
            sa = $urandom_range(0, 255);
            n = $urandom_range(0, 4);
            lat_q = '{};
            for (int i = 0; i < n; i++) begin
                mem[8'(sa + i)] = 16'($urandom_range(0, 16'hFFFE));
                to = $urandom_range(0, 7);
                lat_q.push_back(to == 0 ? TIMEOUT - 2 : (to == 1 ? TIMEOUT - 1 : $urandom_range(0, 6)));
            end
            mem[8'(sa + n)] = HALT;
            spur_en = bit'($urandom_range(0, 1));
            run_prog(8'(sa));
            spur_en = 0;
        end

        // Asynchronous reset in the middle of EXEC
        mem[8'h40] = 16'h1111; mem[8'h41] = HALT;
        core_lat_q = '{30};
        @(negedge clk);
        start_addr = 8'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !bus.run; i++) @(negedge clk);
        chk("pre_rst_run", bus.run, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_run", bus.run, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pc", pc, 0);
        chk("arst_cnt", instr_count, 0);
        chk("arst_rd", bus.mem_rd_en, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_idle", {busy, pc}, 0);
        chk("post_rst_cnt", instr_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
